// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Used by the packet receiver, the UART control FSM and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int PACKET_WIDTH_DEF = 18;
  localparam int OVERSAMPLE_DEF   = 16;
  localparam int SAMPLE_POINT     = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line conditioning: 2-flop synchroniser, armed falling-edge detect and the
// decided-bit value. Macro UART_RX_MAJORITY_EN: decided bit is a 3-sample majority.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic bit_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, armed_q;
`ifdef UART_RX_MAJORITY_EN
  logic prev2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      prev2_q <= 1'b0;
`endif
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      armed_q <= armed_q | sync_q;
`ifdef UART_RX_MAJORITY_EN
      prev2_q <= prev_q;
`endif
    end
  end

  // A line that has never been seen high (or is stuck low) cannot start a frame.
  assign fall_o = armed_q & prev_q & ~sync_q;

`ifdef UART_RX_MAJORITY_EN
  assign bit_o = maj3(sync_q, prev_q, prev2_q);
`else
  assign bit_o = sync_q;
`endif

endmodule

// File: rtl/uart_packet_rx.sv
// 18-bit packet receiver (start 0, LSB first, stop 1) at 16x oversampling, with
// holding buffer, parity/framing/overrun flags. Macro UART_RX_MAJORITY_EN selects
// majority-vote bit decisions in uart_rx_sync.
module uart_packet_rx
  import uart_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_in,
  input  logic                    uld_rx_data,
  output logic [PACKET_WIDTH-1:0] rx_data,
  output logic                    rx_empty,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(PACKET_WIDTH);
  localparam int MID = OVERSAMPLE / 2;

  logic bit_s, fall_s;

  uart_rx_sync u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .rx_i    (rx_in),
    .bit_o   (bit_s),
    .fall_o  (fall_s)
  );

  rx_state_t               state_q;
  logic [SW-1:0]           scnt_q;
  logic [BW-1:0]           bcnt_q;
  logic [PACKET_WIDTH-1:0] shift_q, shift_d;
  logic [PACKET_WIDTH-1:0] rx_data_q;
  logic                    rx_empty_q, perr_q, ferr_q, ovr_q;
  logic                    mid_d, unload_d;

  assign mid_d    = (scnt_q == SW'(MID));
  assign shift_d  = {bit_s, shift_q[PACKET_WIDTH-1:1]};
  assign unload_d = uld_rx_data & ~rx_empty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_empty_q <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (unload_d) begin
        rx_empty_q <= 1'b1;
        ovr_q      <= 1'b0;
      end
      scnt_q <= scnt_q + SW'(1);
      case (state_q)
        IDLE: begin
          // The edge cycle is sample 0 of the start bit, so the count resumes at 1.
          scnt_q <= fall_s ? SW'(1) : '0;
          if (fall_s) state_q <= START;
        end
        START: begin
          bcnt_q <= '0;
          if (mid_d) state_q <= bit_s ? IDLE : DATA;
        end
        DATA: begin
          if (mid_d) begin
            shift_q <= shift_d;
            bcnt_q  <= bcnt_q + BW'(1);
            if (bcnt_q == BW'(PACKET_WIDTH - 1)) state_q <= STOP;
          end
        end
        STOP: begin
          if (mid_d) begin
            rx_data_q  <= shift_q;
            rx_empty_q <= 1'b0;
            ferr_q     <= ~bit_s;
            perr_q     <= ~(^shift_q);
            // A same-cycle unload consumes the old packet, so delivery cannot overrun.
            ovr_q      <= uld_rx_data ? 1'b0 : (ovr_q | ~rx_empty_q);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_empty   = rx_empty_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
